// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE array sequencer: state encoding and default geometry.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int N_DEF       = 4;
  localparam int RES_LAT_DEF = 2 * N_DEF + 1;

endpackage

// File: rtl/pe_array_ctrl_delay_line.sv
// Shift-register delay line with synchronous clear; taps[i] is din delayed i+1 cycles,
// OUT_W selects how many of the deepest taps are exposed.
module ctrl_delay_line #(
  parameter int DEPTH = 4,
  parameter int OUT_W = DEPTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             din,
  output logic [OUT_W-1:0] taps
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  always_comb begin
    line_d = {line_q[DEPTH-2:0], din};
    if (clr) line_d = '0;
  end

  always_ff @(posedge clk) begin
    if (res) line_q <= '0;
    else     line_q <= line_d;
  end

  assign taps = line_q[DEPTH-1 -: OUT_W];

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for an N x N PE16 array: weight preload, skewed vector feed,
// pipeline drain and result-column flagging.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int AW      = 10,
  parameter int VW      = 16,
  parameter int RES_LAT = 2 * N + 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          abort,
  input  logic          width_cfg,
  input  logic [VW-1:0] num_vec,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  output logic          busy,
  output logic          done,
  output logic          w_rd_en,
  output logic [AW-1:0] w_rd_addr,
  output logic [N-1:0]  w_row_en,
  output logic          x_rd_en,
  output logic [AW-1:0] x_rd_addr,
  output logic [N-1:0]  x_lane_en,
  output logic          pe_enable,
  output logic          pe_width,
  output logic          res_valid,
  output logic [VW-1:0] res_idx
);

  state_e        state_q, state_d;
  logic [VW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] num_vec_q, num_vec_d;
  logic [AW-1:0] w_base_q, w_base_d;
  logic [AW-1:0] x_base_q, x_base_d;
  logic          width_q, width_d;
  logic [N-1:0]  w_row_en_q, w_row_en_d;
  logic [VW-1:0] res_idx_q, res_idx_d;

  // One counter is reused as row index, vector index and drain count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_vec_d = num_vec_q;
    w_base_d  = w_base_q;
    x_base_d  = x_base_q;
    width_d   = width_q;
    w_rd_en   = 1'b0;
    x_rd_en   = 1'b0;
    pe_enable = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          num_vec_d = num_vec;
          w_base_d  = w_base;
          x_base_d  = x_base;
          width_d   = width_cfg;
          state_d   = (num_vec == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        w_rd_en = 1'b1;
        if (cnt_q == VW'(N - 1)) begin
          state_d = FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + VW'(1);
        end
      end
      FEED: begin
        x_rd_en   = 1'b1;
        pe_enable = 1'b1;
        if (cnt_q == num_vec_q - VW'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + VW'(1);
        end
      end
      DRAIN: begin
        pe_enable = 1'b1;
        if (cnt_q == VW'(RES_LAT - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + VW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    w_row_en_d = '0;
    if (w_rd_en && !abort) w_row_en_d = N'(1) << cnt_q;
    res_idx_d = res_idx_q;
    if (abort || state_q == DONE) res_idx_d = '0;
    else if (res_valid)           res_idx_d = res_idx_q + VW'(1);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      num_vec_q  <= '0;
      w_base_q   <= '0;
      x_base_q   <= '0;
      width_q    <= 1'b0;
      w_row_en_q <= '0;
      res_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_vec_q  <= num_vec_d;
      w_base_q   <= w_base_d;
      x_base_q   <= x_base_d;
      width_q    <= width_d;
      w_row_en_q <= w_row_en_d;
      res_idx_q  <= res_idx_d;
    end
  end

  ctrl_delay_line #(.DEPTH(N), .OUT_W(N)) u_lane_dly (
    .clk  (clk),
    .res  (res),
    .clr  (abort),
    .din  (x_rd_en),
    .taps (x_lane_en)
  );

  // Only the deepest tap matters here: it marks a column leaving the bottom row.
  ctrl_delay_line #(.DEPTH(RES_LAT), .OUT_W(1)) u_res_dly (
    .clk  (clk),
    .res  (res),
    .clr  (abort),
    .din  (x_rd_en),
    .taps (res_valid)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pe_width  = busy & width_q;
  assign w_rd_addr = w_rd_en ? (w_base_q + cnt_q[AW-1:0]) : '0;
  assign x_rd_addr = x_rd_en ? (x_base_q + cnt_q[AW-1:0]) : '0;
  assign w_row_en  = w_row_en_q;
  assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed self-checking bench for pe_array_ctrl (N=4, AW=10, VW=16, RES_LAT=9).
module tb_pe_array_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic        abort;
  logic        width_cfg;
  logic [15:0] num_vec;
  logic [9:0]  w_base;
  logic [9:0]  x_base;
  logic        busy;
  logic        done;
  logic        w_rd_en;
  logic [9:0]  w_rd_addr;
  logic [3:0]  w_row_en;
  logic        x_rd_en;
  logic [9:0]  x_rd_addr;
  logic [3:0]  x_lane_en;
  logic        pe_enable;
  logic        pe_width;
  logic        res_valid;
  logic [15:0] res_idx;

  int total = 0;
  int bad   = 0;

  pe_array_ctrl #(.N(4), .AW(10), .VW(16), .RES_LAT(9)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .abort     (abort),
    .width_cfg (width_cfg),
    .num_vec   (num_vec),
    .w_base    (w_base),
    .x_base    (x_base),
    .busy      (busy),
    .done      (done),
    .w_rd_en   (w_rd_en),
    .w_rd_addr (w_rd_addr),
    .w_row_en  (w_row_en),
    .x_rd_en   (x_rd_en),
    .x_rd_addr (x_rd_addr),
    .x_lane_en (x_lane_en),
    .pe_enable (pe_enable),
    .pe_width  (pe_width),
    .res_valid (res_valid),
    .res_idx   (res_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    res = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, done, w_rd_en, w_rd_addr, w_row_en, x_rd_en, x_rd_addr, x_lane_en,
         pe_enable, pe_width, res_valid, res_idx} !== '0) begin
      bad++;
      $display("[TB] FAIL reset.outputs got busy=%b done=%b w_rd_en=%b x_rd_en=%b pe_en=%b res_valid=%b exp all 0",
               busy, done, w_rd_en, x_rd_en, pe_enable, res_valid);
    end
    res = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || pe_enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset.idle got busy=%b pe_en=%b exp 0 0", busy, pe_enable);
    end
  endtask

  // Full timeline: LOAD_W cycles 1..4, FEED 5..7, DRAIN 8..16, DONE 17.
  task automatic test_basic_job;
    logic       e_wre, e_xre, e_pe, e_busy, e_done, e_rv;
    logic [9:0] e_wa, e_xa;
    logic [3:0] e_row, e_lane;
    num_vec = 16'd3; w_base = 10'h010; x_base = 10'h040; width_cfg = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      start = 1'b0;
      e_wre  = (c >= 1 && c <= 4);
      e_wa   = e_wre ? 10'(10'h010 + c - 1) : 10'h000;
      e_row  = (c >= 2 && c <= 5) ? 4'(4'b0001 << (c - 2)) : 4'b0000;
      e_xre  = (c >= 5 && c <= 7);
      e_xa   = e_xre ? 10'(10'h040 + c - 5) : 10'h000;
      for (int r = 0; r < 4; r++) e_lane[r] = (c >= 6 + r && c <= 8 + r);
      e_pe   = (c >= 5 && c <= 16);
      e_busy = (c >= 1 && c <= 17);
      e_done = (c == 17);
      e_rv   = (c >= 14 && c <= 16);
      total += 10;
      if (w_rd_en !== e_wre)   begin bad++; $display("[TB] FAIL basic.w_rd_en c=%0d got=%b exp=%b", c, w_rd_en, e_wre); end
      if (w_rd_addr !== e_wa)  begin bad++; $display("[TB] FAIL basic.w_rd_addr c=%0d got=%h exp=%h", c, w_rd_addr, e_wa); end
      if (w_row_en !== e_row)  begin bad++; $display("[TB] FAIL basic.w_row_en c=%0d got=%b exp=%b", c, w_row_en, e_row); end
      if (x_rd_en !== e_xre)   begin bad++; $display("[TB] FAIL basic.x_rd_en c=%0d got=%b exp=%b", c, x_rd_en, e_xre); end
      if (x_rd_addr !== e_xa)  begin bad++; $display("[TB] FAIL basic.x_rd_addr c=%0d got=%h exp=%h", c, x_rd_addr, e_xa); end
      if (x_lane_en !== e_lane) begin bad++; $display("[TB] FAIL basic.x_lane_en c=%0d got=%b exp=%b", c, x_lane_en, e_lane); end
      if (pe_enable !== e_pe)  begin bad++; $display("[TB] FAIL basic.pe_enable c=%0d got=%b exp=%b", c, pe_enable, e_pe); end
      if (busy !== e_busy || pe_width !== e_busy) begin
        bad++; $display("[TB] FAIL basic.busy_width c=%0d got=%b/%b exp=%b/%b", c, busy, pe_width, e_busy, e_busy);
      end
      if (done !== e_done)     begin bad++; $display("[TB] FAIL basic.done c=%0d got=%b exp=%b", c, done, e_done); end
      if (res_valid !== e_rv)  begin bad++; $display("[TB] FAIL basic.res_valid c=%0d got=%b exp=%b", c, res_valid, e_rv); end
      if (e_rv) begin
        total++;
        if (res_idx !== 16'(c - 14)) begin
          bad++; $display("[TB] FAIL basic.res_idx c=%0d got=%0d exp=%0d", c, res_idx, c - 14);
        end
      end
    end
  endtask

  task automatic test_zero_vec;
    num_vec = 16'd0;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      total += 3;
      if (done !== (c == 1)) begin bad++; $display("[TB] FAIL zero.done c=%0d got=%b exp=%b", c, done, c == 1); end
      if (busy !== (c == 1)) begin bad++; $display("[TB] FAIL zero.busy c=%0d got=%b exp=%b", c, busy, c == 1); end
      if (w_rd_en !== 1'b0 || x_rd_en !== 1'b0 || pe_enable !== 1'b0) begin
        bad++; $display("[TB] FAIL zero.reads c=%0d got w=%b x=%b pe=%b exp 0", c, w_rd_en, x_rd_en, pe_enable);
      end
    end
  endtask

  task automatic test_abort;
    int rv_cnt;
    int done_cnt;
    num_vec = 16'd3; w_base = 10'h020; x_base = 10'h050; width_cfg = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    total++;
    if (x_rd_en !== 1'b1 || x_rd_addr !== 10'h051) begin
      bad++; $display("[TB] FAIL abort.k1 got x_rd_en=%b addr=%h exp 1 051", x_rd_en, x_rd_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, done, w_rd_en, w_rd_addr, w_row_en, x_rd_en, x_rd_addr, x_lane_en,
         pe_enable, pe_width, res_valid, res_idx} !== '0) begin
      bad++;
      $display("[TB] FAIL abort.cleared got busy=%b x_rd_en=%b lanes=%b pe_en=%b width=%b res_idx=%0d exp all 0",
               busy, x_rd_en, x_lane_en, pe_enable, pe_width, res_idx);
    end
    rv_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (res_valid) rv_cnt++;
      if (done || busy) done_cnt++;
    end
    total++;
    if (rv_cnt != 0 || done_cnt != 0) begin
      bad++; $display("[TB] FAIL abort.quiet got res_valid=%0d done_or_busy=%0d exp 0 0", rv_cnt, done_cnt);
    end
    num_vec = 16'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort.start_tie got busy=%b exp 0", busy); end
    // Clean follow-up job: FEED 5..6, res_valid 14..15, DONE 16.
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      start = 1'b0;
      total += 2;
      if (done !== (c == 16)) begin bad++; $display("[TB] FAIL abort.rerun_done c=%0d got=%b exp=%b", c, done, c == 16); end
      if (res_valid !== (c == 14 || c == 15)) begin
        bad++; $display("[TB] FAIL abort.rerun_valid c=%0d got=%b exp=%b", c, res_valid, c == 14 || c == 15);
      end
    end
  endtask

  task automatic test_reset_mid_job;
    num_vec = 16'd3; width_cfg = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    res = 1'b1;
    tick();
    res = 1'b0;
    total++;
    if (busy !== 1'b0 || x_rd_en !== 1'b0 || x_lane_en !== 4'b0000 || pe_width !== 1'b0 || w_row_en !== 4'b0000) begin
      bad++; $display("[TB] FAIL resmid.cleared got busy=%b x_rd_en=%b lanes=%b width=%b row=%b exp 0",
                      busy, x_rd_en, x_lane_en, pe_width, w_row_en);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL resmid.res_valid c=%0d got=%b exp=0", c, res_valid); end
    end
  endtask

  // x_base 0x3FE and w_base 0x3FD both wrap at 2^10; DONE at cycle 18.
  task automatic test_wrap;
    logic [9:0] e_xa, e_wa;
    num_vec = 16'd4; w_base = 10'h3FD; x_base = 10'h3FE; width_cfg = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      e_wa = (c >= 1 && c <= 4) ? 10'(10'h3FD + c - 1) : 10'h000;
      e_xa = (c >= 5 && c <= 8) ? 10'(10'h3FE + c - 5) : 10'h000;
      total += 4;
      if (w_rd_addr !== e_wa) begin bad++; $display("[TB] FAIL wrap.w_rd_addr c=%0d got=%h exp=%h", c, w_rd_addr, e_wa); end
      if (x_rd_addr !== e_xa) begin bad++; $display("[TB] FAIL wrap.x_rd_addr c=%0d got=%h exp=%h", c, x_rd_addr, e_xa); end
      if (done !== (c == 18)) begin bad++; $display("[TB] FAIL wrap.done c=%0d got=%b exp=%b", c, done, c == 18); end
      if (pe_width !== 1'b0)  begin bad++; $display("[TB] FAIL wrap.pe_width c=%0d got=%b exp=0", c, pe_width); end
    end
  endtask

  // start held: job 1 busy 1..15, IDLE 16, job 2 busy 17..31; mid-job input changes ignored.
  task automatic test_back_to_back;
    int  done_cnt;
    logic e_busy, e_xre;
    done_cnt = 0;
    num_vec = 16'd1; x_base = 10'h040; w_base = 10'h000; width_cfg = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) done_cnt++;
      e_busy = (c >= 1 && c <= 15) || (c >= 17 && c <= 31);
      e_xre  = (c == 5) || (c == 21);
      total += 5;
      if (done !== (c == 15 || c == 31)) begin
        bad++; $display("[TB] FAIL b2b.done c=%0d got=%b exp=%b", c, done, c == 15 || c == 31);
      end
      if (busy !== e_busy)   begin bad++; $display("[TB] FAIL b2b.busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      if (x_rd_en !== e_xre) begin bad++; $display("[TB] FAIL b2b.x_rd_en c=%0d got=%b exp=%b", c, x_rd_en, e_xre); end
      if (x_rd_addr !== (e_xre ? 10'h040 : 10'h000)) begin
        bad++; $display("[TB] FAIL b2b.x_rd_addr c=%0d got=%h exp=%h", c, x_rd_addr, e_xre ? 10'h040 : 10'h000);
      end
      if (pe_width !== 1'b0) begin bad++; $display("[TB] FAIL b2b.pe_width c=%0d got=%b exp=0", c, pe_width); end
      if (c == 18) begin
        num_vec = 16'd5; x_base = 10'h100; width_cfg = 1'b1;
      end
      if (c == 20) start = 1'b0;
    end
    total++;
    if (done_cnt != 2) begin bad++; $display("[TB] FAIL b2b.done_count got=%0d exp=2", done_cnt); end
  endtask

  initial begin
    res = 1'b1; start = 1'b0; abort = 1'b0; width_cfg = 1'b0;
    num_vec = '0; w_base = '0; x_base = '0;
    test_reset();
    test_basic_job();
    test_zero_vec();
    test_abort();
    test_reset_mid_job();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
